// File: rtl/float16_pkg.sv
// float16 field layout, constants and NaN/Inf classifiers.
// Shared by the add stream controller and its result FIFO.
package float16_pkg;

  localparam int FLOAT_LEN = 16;
  localparam int EXP_LEN   = 5;
  localparam int MANT_LEN  = 10;
  localparam logic [FLOAT_LEN-1:0] QNAN = 16'h7E00;

  typedef struct packed {
    logic                sign;
    logic [EXP_LEN-1:0]  exp;
    logic [MANT_LEN-1:0] mant;
  } fp16_t;

  function automatic logic is_nan(input fp16_t f);
    return (&f.exp) && (|f.mant);
  endfunction

  function automatic logic is_inf(input fp16_t f);
    return (&f.exp) && !(|f.mant);
  endfunction

endpackage

// File: rtl/float16_result_fifo.sv
// Synchronous FIFO for tagged adder results.
// Ports: clk/rst, wr_en/wr_data, rd_en/rd_data, empty/full/count.
module float16_result_fifo
  import float16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en && !full) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/float16_add_stream_ctrl.sv
// Valid/ready wrapper around a fixed-latency float16 adder.
// Ports: in_* stream, add_* adder side, out_* stream, busy.
module float16_add_stream_ctrl
  import float16_pkg::*;
#(
  parameter int FLOAT_LEN = 16,
  parameter int ADD_LAT   = 2,
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLOAT_LEN-1:0] in_a,
  input  logic [FLOAT_LEN-1:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic [FLOAT_LEN-1:0] add_a,
  output logic [FLOAT_LEN-1:0] add_b,
  input  logic [FLOAT_LEN-1:0] add_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLOAT_LEN-1:0] out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_nan,
  output logic                 out_inf,
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;
  localparam int EW = FLOAT_LEN + TAG_W + 2;

  typedef struct packed {
    logic                 nan;
    logic                 inf;
    logic [TAG_W-1:0]     tag;
    logic [FLOAT_LEN-1:0] data;
  } entry_t;

  logic [ADD_LAT-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [ADD_LAT];
  logic [CW-1:0]      inflight_q;
  logic [AW:0]        count;
  logic               issue;
  logic               capture;
  logic               pop;
  logic               empty;
  logic               full;
  fp16_t              res_f;
  entry_t             wr_e;
  entry_t             rd_e;

  assign add_a = in_a;
  assign add_b = in_b;

  // Every accepted pair already owns a FIFO slot,
  // so captures can never overflow.
  assign in_ready = (inflight_q + CW'(count)) < CW'(DEPTH);
  assign issue    = in_valid & in_ready;
  assign capture  = vld_q[ADD_LAT-1];
  assign pop      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      inflight_q <= '0;
    end else begin
      vld_q[0] <= issue;
      for (int i = 1; i < ADD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      inflight_q <= inflight_q + CW'(issue) - CW'(capture);
    end
  end

  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    for (int i = 1; i < ADD_LAT; i++) begin
      tag_q[i] <= tag_q[i-1];
    end
  end

  assign res_f     = add_result;
  assign wr_e.nan  = is_nan(res_f);
  assign wr_e.inf  = is_inf(res_f);
  assign wr_e.tag  = tag_q[ADD_LAT-1];
  assign wr_e.data = add_result;

  float16_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (wr_e),
    .rd_en   (pop),
    .rd_data (rd_e),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  assign out_valid = ~empty;
  assign out_data  = rd_e.data;
  assign out_tag   = rd_e.tag;
  assign out_nan   = rd_e.nan;
  assign out_inf   = rd_e.inf;

  assign busy = (inflight_q != '0) | (count != '0);

  a_count_le_depth: assert property (
    @(posedge clk) disable iff (rst)
    CW'(count) <= CW'(DEPTH)
  );

  a_no_full_capture: assert property (
    @(posedge clk) disable iff (rst)
    !(capture && full && !pop)
  );

endmodule

// File: tb/tb_float16_add_stream_ctrl.sv
// Directed bench for float16_add_stream_ctrl.
// Adder stub with 2-cycle latency plus an in-order scoreboard.
module tb_float16_add_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_tag;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  logic        out_nan;
  logic        out_inf;
  logic        busy;

  typedef struct packed {
    logic        nan;
    logic        inf;
    logic [3:0]  tag;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  bit   sb_on   = 1'b0;

  logic [15:0] t2_a [3] = '{16'h3C00, 16'h7C00, 16'h7C00};
  logic [15:0] t2_b [3] = '{16'hBC00, 16'hFC00, 16'h3C00};
  logic [15:0] t2_d [3] = '{16'h0000, 16'h7E00, 16'h7C00};
  logic        t2_n [3] = '{1'b0, 1'b1, 1'b0};
  logic        t2_i [3] = '{1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  float16_add_stream_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_nan    (out_nan),
    .out_inf    (out_inf),
    .busy       (busy)
  );

  function automatic logic [15:0] fake_add(
    input logic [15:0] a,
    input logic [15:0] b
  );
    if (a == 16'h3C00 && b == 16'h3C00) return 16'h4000;
    if (a == 16'h3C00 && b == 16'hBC00) return 16'h0000;
    if (a == 16'h7C00 && b == 16'hFC00) return 16'h7E00;
    if (a == 16'h7C00 && b == 16'h3C00) return 16'h7C00;
    return a ^ {b[7:0], b[15:8]};
  endfunction

  logic [15:0] a_q, b_q, r_q;
  always @(posedge clk) begin
    a_q <= add_a;
    b_q <= add_b;
    r_q <= fake_add(a_q, b_q);
  end
  assign add_result = r_q;

  function automatic exp_t mk(
    input logic [15:0] d,
    input logic [3:0]  t
  );
    exp_t e;
    e.data = d;
    e.tag  = t;
    e.nan  = (d[14:10] == 5'h1F) && (d[9:0] != 10'h0);
    e.inf  = (d[14:10] == 5'h1F) && (d[9:0] == 10'h0);
    return e;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    if (sb_on) begin
      if (in_valid && in_ready)
        exp_q.push_back(mk(fake_add(in_a, in_b), in_tag));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("sb_extra", 32'(out_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_data", 32'(out_data), 32'(e.data));
          check("sb_tag", 32'(out_tag), 32'(e.tag));
          check("sb_nan", 32'(out_nan), 32'(e.nan));
          check("sb_inf", 32'(out_inf), 32'(e.inf));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag, input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(out_valid), 32'(1));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'(0));
    check({tag, "_left"}, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int n;
    int stalls;
    int ovc;
    int base;
    int stale;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 16'h1234;
    in_b      = 16'h5678;
    in_tag    = 4'h0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'(1));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_data", 32'(out_data), 32'(0));
    check("rst_tag", 32'(out_tag), 32'(0));
    check("rst_nan", 32'(out_nan), 32'(0));
    check("rst_inf", 32'(out_inf), 32'(0));
    check("rst_add_a", 32'(add_a), 32'h1234);
    check("rst_add_b", 32'(add_b), 32'h5678);
    rst   = 1'b0;
    sb_on = 1'b1;
    tick();

    // 1 + 1, tag 3: valid exactly 3 cycles after issue
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 16'h3C00;
    in_b      = 16'h3C00;
    in_tag    = 4'd3;
    check("t1_ready", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    check("t1_c1", 32'(out_valid), 32'(0));
    tick();
    check("t1_c2", 32'(out_valid), 32'(0));
    tick();
    check("t1_c3", 32'(out_valid), 32'(1));
    check("t1_data", 32'(out_data), 32'h4000);
    check("t1_tag", 32'(out_tag), 32'd3);
    check("t1_nan", 32'(out_nan), 32'(0));
    check("t1_inf", 32'(out_inf), 32'(0));
    tick();
    drain("t1_drain");

    // zero, NaN and Inf results back to back
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a   = t2_a[i];
      in_b   = t2_b[i];
      in_tag = 4'(i + 5);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_out("t2_wait", 10);
      check("t2_data", 32'(out_data), 32'(t2_d[i]));
      check("t2_tag", 32'(out_tag), 32'(i + 5));
      check("t2_nan", 32'(out_nan), 32'(t2_n[i]));
      check("t2_inf", 32'(out_inf), 32'(t2_i[i]));
      tick();
    end
    drain("t2_drain");

    // backpressure: exactly DEPTH accepted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc       = 0;
    for (int c = 0; c < 8; c++) begin
      in_tag = 4'(acc);
      in_a   = 16'($urandom);
      in_b   = 16'($urandom);
      if (in_ready) acc++;
      tick();
    end
    check("bp_acc", 32'(acc), 32'd4);
    check("bp_ready", 32'(in_ready), 32'(0));
    check("bp_valid", 32'(out_valid), 32'(1));
    check("bp_head", 32'(out_tag), 32'd0);
    out_ready = 1'b1;
    n = 0;
    while (acc < 6 && n < 20) begin
      in_tag = 4'(acc);
      if (in_ready) acc++;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("bp_acc2", 32'(acc), 32'd6);
    drain("bp_drain");

    // 3 buffered + 1 in flight; pop returns credit next cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_tag = 4'(i + 8);
      in_a   = 16'($urandom);
      in_b   = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("sim_n_ready", 32'(in_ready), 32'(0));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_tag    = 4'd12;
    tick();
    check("sim_n1_ready", 32'(in_ready), 32'(1));
    tick();
    drain("sim_drain");

    // streaming: one result per cycle, no stalls
    base      = n_out;
    stalls    = 0;
    ovc       = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_a   = 16'($urandom);
      in_b   = 16'($urandom);
      in_tag = 4'($urandom);
      if (!in_ready) stalls++;
      if (out_valid) ovc++;
      tick();
    end
    in_valid = 1'b0;
    check("st_stalls", 32'(stalls), 32'd0);
    check("st_ovc", 32'(ovc), 32'd17);
    drain("st_drain");
    check("st_count", 32'(n_out - base), 32'd20);

    // reset with 2 in flight and 2 buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_tag = 4'(i);
      in_a   = 16'($urandom);
      in_b   = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    check("mr_busy", 32'(busy), 32'(1));
    check("mr_valid", 32'(out_valid), 32'(1));
    rst   = 1'b1;
    sb_on = 1'b0;
    exp_q.delete();
    tick();
    check("mr_rst_valid", 32'(out_valid), 32'(0));
    check("mr_rst_busy", 32'(busy), 32'(0));
    check("mr_rst_ready", 32'(in_ready), 32'(1));
    rst       = 1'b0;
    out_ready = 1'b1;
    stale     = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid || busy) stale++;
    end
    check("mr_stale", 32'(stale), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/float16_add_stream_ctrl.md
Name: float16_add_stream_ctrl

Overview:
- Valid/ready stream front-end and back-end for the float16 adder datapath, which has a fixed 2-cycle latency (input register plus output register, no stall input).
- Accepts operand pairs with a tag, issues them to the adder, and aligns each returned sum with its tag.
- Buffers results in an output FIFO and flags NaN/Inf results.
- Credit-based admission guarantees that no in-flight result is ever dropped under downstream backpressure.

Parameters:
- FLOAT_LEN, 16, operand/result width
- ADD_LAT, 2, adder latency in cycles from operands driven to result valid (must be ≥1)
- DEPTH, 4, output FIFO entries, power of two, must be ≥ ADD_LAT
- TAG_W, 4, width of the sideband tag carried with each operation

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept the pair
- in_a  in  FLOAT_LEN  operand a
- in_b  in  FLOAT_LEN  operand b
- in_tag  in  TAG_W  sideband tag
- add_a  out  FLOAT_LEN  operand a to adder
- add_b  out  FLOAT_LEN  operand b to adder
- add_result  in  FLOAT_LEN  adder result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_data  out  FLOAT_LEN  sum
- out_tag  out  TAG_W  tag of the sum
- out_nan  out  1  out_data exponent is 0x1F and mantissa ≠ 0
- out_inf  out  1  out_data exponent is 0x1F and mantissa = 0
- busy  out  1  any operation in flight or buffered

Behaviour:
- Reset (synchronous, active-high; "clk" and "rst" as named above):
  - Clears the valid shift register, FIFO pointers, and counters.
  - After reset: in_ready=1, out_valid=0, busy=0, out_data/out_tag/out_nan/out_inf=0.
  - add_a/add_b are combinational, so they follow in_a/in_b during reset.
- Issue:
  - issue = in_valid & in_ready.
  - add_a=in_a and add_b=in_b, combinational, every cycle. The adder samples every cycle; only issued cycles are tracked.
  - The tag and issue bit enter an ADD_LAT-deep shift register (stage 0 loads on the same edge).
- Capture:
  - When shift-register stage ADD_LAT-1 is valid, add_result is written into the FIFO with its tag, together with nan/inf flags decoded from add_result.
  - Capture happens at the end of cycle t+ADD_LAT for a pair issued in cycle t.
- Output:
  - out_valid=1 when the FIFO is non-empty. out_* come registered from the FIFO head.
  - Pop when out_valid & out_ready.
  - Minimum issue-to-out_valid latency is ADD_LAT+1 cycles (3 by default).
  - Results are strictly in issue order.
- Credit:
  - inflight = number of valid shift-register stages; count = FIFO occupancy. Both are registered.
  - in_ready = (inflight + count) < DEPTH. It depends on registered state only, never combinationally on in_valid or out_ready.
  - A pop in a cycle does not raise in_ready in that same cycle; the credit returns on the next cycle.
- Simultaneous events:
  - Issue, capture, and pop in one cycle update every counter consistently. Net occupancy change = issue − pop.
  - Capture into a full FIFO is impossible by construction. An assertion checks count ≤ DEPTH.
- Wrap-around: FIFO pointers are log2(DEPTH)+1 bits wide; full/empty are decided by the MSB compare.
- Reset mid-operation: all in-flight and buffered results are discarded. Late add_result values arriving after reset are ignored because the valid bits are cleared.
- busy = (inflight ≠ 0) | (count ≠ 0).
- No arithmetic is performed here. The result word passes through unmodified.

Decomposition:
- Shared package float16_pkg:
  - Constants FLOAT_LEN, EXP_LEN=5, MANT_LEN=10, QNAN=16'h7E00.
  - A typedef for the float16 fields (sign/exp/mant struct).
  - is_nan/is_inf functions.
- One sub-module: float16_result_fifo, a synchronous FIFO with parameters DEPTH and width. The top level holds the shift register, counters, and flag decode.

Test Plan:
- 1+1: 0x3C00 + 0x3C00 with tag 3, out_ready=1 → out_valid in cycle 3 after issue, out_data=0x4000, out_tag=3, out_nan=0, out_inf=0.
- 1 + (−1): 0x3C00 + 0xBC00 → out_data=0x0000. Then +Inf + −Inf (0x7C00 + 0xFC00) → out_data=0x7E00, out_nan=1. Then 0x7C00 + 0x3C00 → 0x7C00, out_inf=1.
- Backpressure: DEPTH=4, out_ready=0, in_valid held with tags 0..5 → exactly 4 accepted, in_ready=0 from then on. Release out_ready → tags 0,1,2,3 out in order, then 4 and 5 are accepted.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with random pairs, checked against the reference model → one result per cycle, no stalls, no loss, order preserved.
- Simultaneous events: FIFO holding 3 entries plus 1 in flight; issue blocked (in_ready=0); pop in cycle N → in_ready=1 in cycle N+1, not in N.
- Reset mid-operation: assert rst with 2 in flight and 2 buffered → next cycle out_valid=0, busy=0, in_ready=1, and no stale results emerge over the following 5 cycles.
